// File: rtl/alu_issue_queue.sv
// Collapsing-queue reservation station for the single-cycle ALU: oldest-ready issue, CDB wakeup.
// Optional `ALU_IQ_PERF_EN adds saturating issue and dispatch-stall counters.
module alu_issue_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ROB_W  = 3,
    parameter int unsigned PREG_W = 7
) (
`ifdef ALU_IQ_PERF_EN
    output logic [31:0]                 perf_issue_cnt,
    output logic [31:0]                 perf_full_cnt,
`endif
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        disp_valid,
    output logic                        disp_ready,
    input  logic [4:0]                  disp_opcode,
    input  logic [2:0]                  disp_funct3,
    input  logic                        disp_funct7,
    input  logic [31:0]                 disp_imm,
    input  logic [31:0]                 disp_pc,
    input  logic [ROB_W-1:0]            disp_rob_idx,
    input  logic [PREG_W-1:0]           disp_rd,
    input  logic [PREG_W-1:0]           disp_rs1_tag,
    input  logic [PREG_W-1:0]           disp_rs2_tag,
    input  logic                        disp_rs1_rdy,
    input  logic                        disp_rs2_rdy,
    input  logic [31:0]                 disp_rs1_data,
    input  logic [31:0]                 disp_rs2_data,
    input  logic                        cdb_valid,
    input  logic [PREG_W-1:0]           cdb_rd,
    input  logic [31:0]                 cdb_data,
    input  logic                        flush,
    output logic                        alu_i_valid,
    output logic [4:0]                  alu_opcode,
    output logic [2:0]                  alu_funct3,
    output logic                        alu_funct7,
    output logic [31:0]                 alu_imm,
    output logic [31:0]                 alu_pc,
    output logic [31:0]                 alu_rs1_data,
    output logic [31:0]                 alu_rs2_data,
    output logic [ROB_W-1:0]            alu_i_rob_idx,
    output logic [PREG_W-1:0]           alu_i_rd,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic [4:0]        opcode;
        logic [2:0]        funct3;
        logic              funct7;
        logic [31:0]       imm;
        logic [31:0]       pc;
        logic [ROB_W-1:0]  rob_idx;
        logic [PREG_W-1:0] rd;
        logic [PREG_W-1:0] rs1_tag;
        logic              rs1_rdy;
        logic [31:0]       rs1_data;
        logic [PREG_W-1:0] rs2_tag;
        logic              rs2_rdy;
        logic [31:0]       rs2_data;
    } entry_t;

    entry_t          ent_q [DEPTH];
    entry_t          ent_d [DEPTH];
    // One spare zero entry on top so the shift-down never indexes past the array.
    entry_t          woken [DEPTH+1];
    entry_t          disp_ent;
    entry_t          sel_ent;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            sel_found;
    int              sel_idx;
    int              wr_idx;
    logic            issue_fire;
    logic            disp_fire;

    assign disp_ready = (count_q < CW'(DEPTH));
    assign disp_fire  = disp_valid && disp_ready && !flush;
    assign count      = count_q;

    // Oldest ready entry; entry 0 is always the oldest.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 0;
        sel_ent   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (!sel_found && ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
                sel_found = 1'b1;
                sel_idx   = i;
                sel_ent   = ent_q[i];
            end
        end
    end

    assign issue_fire = sel_found && !flush;

    always_comb begin
        alu_i_valid   = issue_fire;
        alu_opcode    = '0;
        alu_funct3    = '0;
        alu_funct7    = 1'b0;
        alu_imm       = '0;
        alu_pc        = '0;
        alu_rs1_data  = '0;
        alu_rs2_data  = '0;
        alu_i_rob_idx = '0;
        alu_i_rd      = '0;
        if (issue_fire) begin
            alu_opcode    = sel_ent.opcode;
            alu_funct3    = sel_ent.funct3;
            alu_funct7    = sel_ent.funct7;
            alu_imm       = sel_ent.imm;
            alu_pc        = sel_ent.pc;
            alu_rs1_data  = sel_ent.rs1_data;
            alu_rs2_data  = sel_ent.rs2_data;
            alu_i_rob_idx = sel_ent.rob_idx;
            alu_i_rd      = sel_ent.rd;
        end
    end

    // Incoming micro-op, with an operand captured straight off the CDB if it broadcasts now.
    always_comb begin
        disp_ent          = '0;
        disp_ent.valid    = 1'b1;
        disp_ent.opcode   = disp_opcode;
        disp_ent.funct3   = disp_funct3;
        disp_ent.funct7   = disp_funct7;
        disp_ent.imm      = disp_imm;
        disp_ent.pc       = disp_pc;
        disp_ent.rob_idx  = disp_rob_idx;
        disp_ent.rd       = disp_rd;
        disp_ent.rs1_tag  = disp_rs1_tag;
        disp_ent.rs1_rdy  = disp_rs1_rdy;
        disp_ent.rs1_data = disp_rs1_data;
        disp_ent.rs2_tag  = disp_rs2_tag;
        disp_ent.rs2_rdy  = disp_rs2_rdy;
        disp_ent.rs2_data = disp_rs2_data;
        if (cdb_valid && !disp_rs1_rdy && (disp_rs1_tag == cdb_rd)) begin
            disp_ent.rs1_rdy  = 1'b1;
            disp_ent.rs1_data = cdb_data;
        end
        if (cdb_valid && !disp_rs2_rdy && (disp_rs2_tag == cdb_rd)) begin
            disp_ent.rs2_rdy  = 1'b1;
            disp_ent.rs2_data = cdb_data;
        end
    end

    // Wakeup first, then collapse over the issued slot, then append the dispatch.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            woken[i] = ent_q[i];
            if (cdb_valid && ent_q[i].valid) begin
                if (!ent_q[i].rs1_rdy && (ent_q[i].rs1_tag == cdb_rd)) begin
                    woken[i].rs1_rdy  = 1'b1;
                    woken[i].rs1_data = cdb_data;
                end
                if (!ent_q[i].rs2_rdy && (ent_q[i].rs2_tag == cdb_rd)) begin
                    woken[i].rs2_rdy  = 1'b1;
                    woken[i].rs2_data = cdb_data;
                end
            end
        end
        woken[DEPTH] = '0;

        wr_idx = int'(count_q) - int'(issue_fire);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (issue_fire && (i >= sel_idx)) begin
                ent_d[i] = woken[i+1];
            end else begin
                ent_d[i] = woken[i];
            end
            if (disp_fire && (i == wr_idx)) begin
                ent_d[i] = disp_ent;
            end
            if (flush) begin
                ent_d[i] = '0;
            end
        end

        if (flush) begin
            count_d = '0;
        end else begin
            count_d = CW'(int'(count_q) + int'(disp_fire) - int'(issue_fire));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q <= count_d;
        end
    end

`ifdef ALU_IQ_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_cnt <= '0;
            perf_full_cnt  <= '0;
        end else begin
            if (issue_fire && (perf_issue_cnt != 32'hFFFF_FFFF)) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
            if (disp_valid && !disp_ready && (perf_full_cnt != 32'hFFFF_FFFF)) begin
                perf_full_cnt <= perf_full_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed self-checking bench for alu_issue_queue (DEPTH=4, ROB_W=3, PREG_W=7).
module tb_alu_issue_queue;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ROB_W  = 3;
    localparam int unsigned PREG_W = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              disp_valid;
    logic              disp_ready;
    logic [4:0]        disp_opcode;
    logic [2:0]        disp_funct3;
    logic              disp_funct7;
    logic [31:0]       disp_imm;
    logic [31:0]       disp_pc;
    logic [ROB_W-1:0]  disp_rob_idx;
    logic [PREG_W-1:0] disp_rd;
    logic [PREG_W-1:0] disp_rs1_tag;
    logic [PREG_W-1:0] disp_rs2_tag;
    logic              disp_rs1_rdy;
    logic              disp_rs2_rdy;
    logic [31:0]       disp_rs1_data;
    logic [31:0]       disp_rs2_data;
    logic              cdb_valid;
    logic [PREG_W-1:0] cdb_rd;
    logic [31:0]       cdb_data;
    logic              flush;
    logic              alu_i_valid;
    logic [4:0]        alu_opcode;
    logic [2:0]        alu_funct3;
    logic              alu_funct7;
    logic [31:0]       alu_imm;
    logic [31:0]       alu_pc;
    logic [31:0]       alu_rs1_data;
    logic [31:0]       alu_rs2_data;
    logic [ROB_W-1:0]  alu_i_rob_idx;
    logic [PREG_W-1:0] alu_i_rd;
    logic [2:0]        count;
`ifdef ALU_IQ_PERF_EN
    logic [31:0]       perf_issue_cnt;
    logic [31:0]       perf_full_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    alu_issue_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W), .PREG_W(PREG_W)) dut (
`ifdef ALU_IQ_PERF_EN
        .perf_issue_cnt (perf_issue_cnt),
        .perf_full_cnt  (perf_full_cnt),
`endif
        .clk            (clk),
        .rst            (rst),
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_opcode    (disp_opcode),
        .disp_funct3    (disp_funct3),
        .disp_funct7    (disp_funct7),
        .disp_imm       (disp_imm),
        .disp_pc        (disp_pc),
        .disp_rob_idx   (disp_rob_idx),
        .disp_rd        (disp_rd),
        .disp_rs1_tag   (disp_rs1_tag),
        .disp_rs2_tag   (disp_rs2_tag),
        .disp_rs1_rdy   (disp_rs1_rdy),
        .disp_rs2_rdy   (disp_rs2_rdy),
        .disp_rs1_data  (disp_rs1_data),
        .disp_rs2_data  (disp_rs2_data),
        .cdb_valid      (cdb_valid),
        .cdb_rd         (cdb_rd),
        .cdb_data       (cdb_data),
        .flush          (flush),
        .alu_i_valid    (alu_i_valid),
        .alu_opcode     (alu_opcode),
        .alu_funct3     (alu_funct3),
        .alu_funct7     (alu_funct7),
        .alu_imm        (alu_imm),
        .alu_pc         (alu_pc),
        .alu_rs1_data   (alu_rs1_data),
        .alu_rs2_data   (alu_rs2_data),
        .alu_i_rob_idx  (alu_i_rob_idx),
        .alu_i_rd       (alu_i_rd),
        .count          (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        disp_valid    = 1'b0;
        disp_opcode   = '0;
        disp_funct3   = '0;
        disp_funct7   = 1'b0;
        disp_imm      = '0;
        disp_pc       = '0;
        disp_rob_idx  = '0;
        disp_rd       = '0;
        disp_rs1_tag  = '0;
        disp_rs2_tag  = '0;
        disp_rs1_rdy  = 1'b0;
        disp_rs2_rdy  = 1'b0;
        disp_rs1_data = '0;
        disp_rs2_data = '0;
        cdb_valid     = 1'b0;
        cdb_rd        = '0;
        cdb_data      = '0;
        flush         = 1'b0;
    endtask

    // ADD-class op; pc is 0x1000 + 4*rob.
    task automatic disp(input logic [ROB_W-1:0] rob, input logic [PREG_W-1:0] rd,
                        input logic [PREG_W-1:0] t1, input logic r1, input logic [31:0] d1,
                        input logic [PREG_W-1:0] t2, input logic r2, input logic [31:0] d2);
        disp_valid    = 1'b1;
        disp_opcode   = 5'b01100;
        disp_funct3   = 3'b000;
        disp_funct7   = 1'b0;
        disp_imm      = 32'h0;
        disp_pc       = 32'h1000 + 32'(rob) * 4;
        disp_rob_idx  = rob;
        disp_rd       = rd;
        disp_rs1_tag  = t1;
        disp_rs1_rdy  = r1;
        disp_rs1_data = d1;
        disp_rs2_tag  = t2;
        disp_rs2_rdy  = r2;
        disp_rs2_data = d2;
    endtask

    task automatic cdb(input logic [PREG_W-1:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_rd    = tag;
        cdb_data  = data;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_ready", 32'(disp_ready), 1);
        chk("rst_ivalid", 32'(alu_i_valid), 0);
        chk("rst_pc", alu_pc, 0);
        tick();
        rst = 1'b0;
        tick();

        // Ready ADD issues the cycle after dispatch.
        disp(3'd2, 7'h10, 7'h01, 1'b1, 32'd5, 7'h02, 1'b1, 32'd7);
        #1 chk("add_c0_ivalid", 32'(alu_i_valid), 0);
        tick();
        idle_inputs();
        chk("add_ivalid", 32'(alu_i_valid), 1);
        chk("add_rs1", alu_rs1_data, 5);
        chk("add_rs2", alu_rs2_data, 7);
        chk("add_rob", 32'(alu_i_rob_idx), 2);
        chk("add_rd", 32'(alu_i_rd), 32'h10);
        chk("add_opcode", 32'(alu_opcode), 32'h0C);
        chk("add_pc", alu_pc, 32'h1008);
        tick();
        chk("add_count", 32'(count), 0);
        chk("add_drain", 32'(alu_i_valid), 0);

        // rs1 waits for a CDB broadcast; no same-cycle bypass.
        disp(3'd3, 7'h11, 7'h12, 1'b0, 32'h0, 7'h03, 1'b1, 32'd1);
        tick();
        idle_inputs();
        chk("wk_wait", 32'(alu_i_valid), 0);
        chk("wk_count", 32'(count), 1);
        tick();
        cdb(7'h12, 32'hDEADBEEF);
        #1 chk("wk_nobypass", 32'(alu_i_valid), 0);
        tick();
        idle_inputs();
        chk("wk_ivalid", 32'(alu_i_valid), 1);
        chk("wk_rs1", alu_rs1_data, 32'hDEADBEEF);
        chk("wk_rs2", alu_rs2_data, 1);
        tick();
        chk("wk_count0", 32'(count), 0);

        // Dispatch and CDB in the same cycle.
        disp(3'd4, 7'h13, 7'h04, 1'b1, 32'd9, 7'h21, 1'b0, 32'h0);
        cdb(7'h21, 32'h55);
        tick();
        idle_inputs();
        chk("col_ivalid", 32'(alu_i_valid), 1);
        chk("col_rs2", alu_rs2_data, 32'h55);
        chk("col_rs1", alu_rs1_data, 9);
        tick();
        chk("col_count0", 32'(count), 0);

        // Fill with four waiting entries; entries 0 and 1 share a tag.
        disp(3'd0, 7'h40, 7'h30, 1'b0, 32'h0, 7'h00, 1'b1, 32'h0);
        tick();
        disp(3'd1, 7'h41, 7'h30, 1'b0, 32'h0, 7'h00, 1'b1, 32'h0);
        tick();
        disp(3'd2, 7'h42, 7'h32, 1'b0, 32'h0, 7'h00, 1'b1, 32'h0);
        tick();
        disp(3'd3, 7'h43, 7'h33, 1'b0, 32'h0, 7'h00, 1'b1, 32'h0);
        tick();
        idle_inputs();
        chk("full_count", 32'(count), 4);
        chk("full_ready", 32'(disp_ready), 0);
        chk("full_ivalid", 32'(alu_i_valid), 0);
        disp(3'd7, 7'h47, 7'h00, 1'b1, 32'h1, 7'h00, 1'b1, 32'h1);
        tick();
        idle_inputs();
        chk("full_reject_count", 32'(count), 4);
        chk("full_reject_ivalid", 32'(alu_i_valid), 0);
        cdb(7'h32, 32'hA2);
        tick();
        idle_inputs();
        chk("mid_ivalid", 32'(alu_i_valid), 1);
        chk("mid_rob", 32'(alu_i_rob_idx), 2);
        chk("mid_rs1", alu_rs1_data, 32'hA2);
        chk("mid_ready_full", 32'(disp_ready), 0);
        tick();
        chk("mid_count", 32'(count), 3);
        chk("mid_ready", 32'(disp_ready), 1);
        chk("mid_idle", 32'(alu_i_valid), 0);
        cdb(7'h30, 32'hB0);
        tick();
        idle_inputs();
        chk("old_first_rob", 32'(alu_i_rob_idx), 0);
        chk("old_first_rs1", alu_rs1_data, 32'hB0);
        // Issue of rob 1 overlaps a dispatch written at count - 1.
        tick();
        chk("old_second_rob", 32'(alu_i_rob_idx), 1);
        chk("old_second_count", 32'(count), 2);
        disp(3'd5, 7'h45, 7'h05, 1'b1, 32'h77, 7'h06, 1'b1, 32'h88);
        tick();
        idle_inputs();
        chk("same_cyc_count", 32'(count), 2);
        chk("same_cyc_rob", 32'(alu_i_rob_idx), 5);
        chk("same_cyc_rs2", alu_rs2_data, 32'h88);
        tick();
        chk("shift_count", 32'(count), 1);
        chk("shift_idle", 32'(alu_i_valid), 0);
        cdb(7'h33, 32'hA3);
        tick();
        idle_inputs();
        chk("shift_rob", 32'(alu_i_rob_idx), 3);
        chk("shift_rs1", alu_rs1_data, 32'hA3);
        tick();
        chk("shift_count0", 32'(count), 0);

        // Flush with three entries, one ready, and a dispatch in the flush cycle.
        disp(3'd0, 7'h50, 7'h50, 1'b0, 32'h0, 7'h00, 1'b1, 32'h0);
        tick();
        disp(3'd1, 7'h51, 7'h51, 1'b0, 32'h0, 7'h00, 1'b1, 32'h0);
        tick();
        disp(3'd2, 7'h52, 7'h00, 1'b1, 32'h3, 7'h00, 1'b1, 32'h4);
        tick();
        idle_inputs();
        chk("fl_pre_ivalid", 32'(alu_i_valid), 1);
        chk("fl_pre_count", 32'(count), 3);
        disp(3'd6, 7'h56, 7'h00, 1'b1, 32'h6, 7'h00, 1'b1, 32'h6);
        flush = 1'b1;
        #1 chk("fl_ivalid", 32'(alu_i_valid), 0);
        tick();
        idle_inputs();
        chk("fl_count", 32'(count), 0);
        chk("fl_next_ivalid", 32'(alu_i_valid), 0);
        tick();
        chk("fl_dropped", 32'(alu_i_valid), 0);

        // Asynchronous reset mid-run with three entries held.
        disp(3'd0, 7'h60, 7'h60, 1'b0, 32'h0, 7'h00, 1'b1, 32'h0);
        tick();
        disp(3'd1, 7'h61, 7'h61, 1'b0, 32'h0, 7'h00, 1'b1, 32'h0);
        tick();
        disp(3'd2, 7'h62, 7'h00, 1'b1, 32'h1, 7'h00, 1'b1, 32'h2);
        tick();
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_ivalid", 32'(alu_i_valid), 0);
        chk("arst_ready", 32'(disp_ready), 1);
        chk("arst_rs1", alu_rs1_data, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_after", 32'(count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
Reservation station feeding the single-cycle ALU in the out-of-order core. Holds dispatched ALU/branch/jump micro-ops until both source operands are available. Snoops the common data bus (CDB) for operand wakeup. Each cycle, issues the oldest ready entry to the ALU's alu_i_* inputs; flushes on a branch/jump redirect.

Parameters:
DEPTH, 4, number of queue entries (2..8).
ROB_W, 3, ROB index width.
PREG_W, 7, destination/source tag width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
disp_valid  in  1  dispatch request
disp_ready  out  1  queue can accept a dispatch this cycle
disp_opcode  in  5  opcode[6:2]
disp_funct3  in  3  funct3
disp_funct7  in  1  funct7 bit 5
disp_imm  in  32  immediate
disp_pc  in  32  instruction PC
disp_rob_idx  in  ROB_W  ROB index
disp_rd  in  PREG_W  destination tag
disp_rs1_tag, disp_rs2_tag  in  PREG_W  source tags
disp_rs1_rdy, disp_rs2_rdy  in  1  operand already available
disp_rs1_data, disp_rs2_data  in  32  operand value (valid when rdy=1)
cdb_valid  in  1  CDB broadcast valid
cdb_rd  in  PREG_W  broadcast tag
cdb_data  in  32  broadcast value
flush  in  1  redirect; kill all entries
alu_i_valid  out  1  issue valid to ALU
alu_opcode, alu_funct3, alu_funct7, alu_imm, alu_pc  out  5/3/1/32/32  issued fields
alu_rs1_data, alu_rs2_data  out  32  issued operands
alu_i_rob_idx  out  ROB_W  issued ROB index
alu_i_rd  out  PREG_W  issued destination tag
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Storage: collapsing queue. Entry 0 is always the oldest; valid entries are contiguous from 0 to count-1.
- Reset (async, rst=1): all entries invalid, count=0, alu_i_valid=0, all alu_* outputs 0, disp_ready=1.
- disp_ready = (count < DEPTH). It does not credit a same-cycle issue. Dispatch is accepted when disp_valid && disp_ready && !flush.
- Select (combinational from registered state): lowest-index entry with valid && rs1_rdy && rs2_rdy. alu_i_valid=1 if one exists and flush=0. alu_* outputs are driven directly from that entry.
- Zero-latency issue: an entry issues the cycle after it is written. The ALU consumes every issue; there is no back-pressure.
- Removal at the clock edge: the issued entry is removed and entries above it shift down by one. An accepted dispatch is written at index (count - issued), so count is unchanged when issue and dispatch happen together.
- Wakeup: on cdb_valid, every valid entry whose operand is not ready and whose tag == cdb_rd sets rdy=1 and captures cdb_data at the edge. Both operands of one entry may match the same broadcast.
- The woken entry is issuable the next cycle. There is no same-cycle CDB-to-issue bypass.
- Dispatch/CDB collision: if a dispatched operand has rdy=0 and tag == cdb_rd with cdb_valid in the same cycle, it is written as ready with cdb_data.
- CDB wakeup applies to entries moving in the same-cycle shift. Tag and data move with the entry.
- Flush: at the next edge all entries are invalidated and count=0. In the flush cycle alu_i_valid=0 and dispatch is dropped. Flush has priority over wakeup, dispatch and issue.
- No ordering is guaranteed across flush beyond the above. ROB-based squash is the ROB's concern.

Optional Feature:
ALU_IQ_PERF_EN
- Defined: adds outputs perf_issue_cnt (32, increments per alu_i_valid) and perf_full_cnt (32, increments per cycle with disp_valid && !disp_ready). Both reset to 0 on rst, saturate at 0xFFFFFFFF, and are not cleared by flush.
- Undefined: ports and counters are absent; core behaviour is identical.

Test Plan:
1. Assert rst mid-run with 3 entries -> immediately count=0, alu_i_valid=0, disp_ready=1.
2. Dispatch ADD with rs1_rdy=rs2_rdy=1, data 5/7, rob_idx 2, rd 0x10 in cycle 0 -> cycle 1: alu_i_valid=1, alu_rs1_data=5, alu_rs2_data=7, alu_i_rob_idx=2, alu_i_rd=0x10; cycle 2: count=0.
3. Dispatch with rs1_tag=0x12 not ready; cycle 2: cdb_valid, cdb_rd=0x12, cdb_data=0xDEADBEEF -> cycle 3 issue with alu_rs1_data=0xDEADBEEF; no issue in cycle 2.
4. Dispatch with rs2_tag=0x21 not ready while cdb_rd=0x21, cdb_data=0x55 in the same cycle -> issues next cycle with alu_rs2_data=0x55.
5. Fill 4 non-ready entries -> disp_ready=0 and a fifth disp_valid is not accepted. Wake entry 2 -> it issues, entry 3 shifts to index 2, disp_ready=1 the following cycle. Make entries 0 and 1 ready together -> entry 0 issues first.
6. 3 entries (one ready) with flush=1 and disp_valid=1 -> alu_i_valid=0 that cycle; next cycle count=0 and nothing issues.
